// File: rtl/dma_xfer_engine.sv
//-----------------------------------------------------------------------------
// dma_xfer_engine
//
// Word-granular memory-to-memory copy engine. A transfer copies cfg_len
// 16-bit words from cfg_src to cfg_dst through one shared memory port. Each
// word is a READ access followed by a WRITE access. Both complete on the
// clock edge where dma_ready is high. An abort from the access-control
// monitor kills the transfer at once and leaves a sticky error flag.
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   start      in   one-cycle transfer request (honoured only in IDLE)
//   cfg_src    in   source byte address (bit 0 forced to 0)
//   cfg_dst    in   destination byte address (bit 0 forced to 0)
//   cfg_len    in   number of words to copy (0 = complete with no bus access)
//   abort      in   level-sensitive kill request
//   dma_addr   out  bus address
//   dma_en     out  bus access valid
//   dma_we     out  1 = write, 0 = read
//   dma_dout   out  write data
//   dma_din    in   read data, valid with dma_ready during a read
//   dma_ready  in   memory completes the current access at this edge
//   busy       out  high while reading or writing
//   done       out  one-cycle pulse on successful completion
//   error      out  sticky abort flag, cleared by the next accepted start
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module dma_xfer_engine #(
    parameter int          LEN_W     = 8,
    parameter logic [15:0] ADDR_STEP = 16'h0002
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [15:0]      cfg_src,
    input  logic [15:0]      cfg_dst,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             abort,
    output logic [15:0]      dma_addr,
    output logic             dma_en,
    output logic             dma_we,
    output logic [15:0]      dma_dout,
    input  logic [15:0]      dma_din,
    input  logic             dma_ready,
    output logic             busy,
    output logic             done,
    output logic             error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [15:0]      r_src;
    logic [15:0]      r_dst;
    logic [15:0]      r_data;
    logic [LEN_W-1:0] r_count;
    logic             r_error;

    logic             w_accept;     // start taken in IDLE
    logic             w_rd_done;    // read completes this edge
    logic             w_wr_done;    // write completes this edge
    logic             w_abort_hit;  // abort kills an active transfer

    //-------------------------------------------------------------------------
    // State register
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    //-------------------------------------------------------------------------
    // Next-state decode. Abort takes priority over dma_ready, so an access
    // that completes on the same edge as an abort is simply dropped.
    //-------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_rd_done    = 1'b0;
        w_wr_done    = 1'b0;
        w_abort_hit  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_accept     = 1'b1;
                    w_state_next = (cfg_len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (abort) begin
                    w_abort_hit  = 1'b1;
                    w_state_next = S_IDLE;
                end else if (dma_ready) begin
                    w_rd_done    = 1'b1;
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (abort) begin
                    w_abort_hit  = 1'b1;
                    w_state_next = S_IDLE;
                end else if (dma_ready) begin
                    w_wr_done    = 1'b1;
                    w_state_next = (r_count == LEN_W'(1)) ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                w_abort_hit  = abort;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    //-------------------------------------------------------------------------
    // Datapath registers
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_data  <= '0;
            r_count <= '0;
            r_error <= 1'b0;
        end else begin
            if (w_accept) begin
                // Word-aligned addresses: byte bit 0 is dropped.
                r_src   <= cfg_src & 16'hFFFE;
                r_dst   <= cfg_dst & 16'hFFFE;
                r_count <= cfg_len;
                r_error <= 1'b0;
            end
            if (w_rd_done) begin
                r_data <= dma_din;
            end
            if (w_wr_done) begin
                // 16-bit add wraps naturally from FFFE to 0000.
                r_src   <= r_src + ADDR_STEP;
                r_dst   <= r_dst + ADDR_STEP;
                r_count <= r_count - LEN_W'(1);
            end
            if (w_abort_hit) begin
                r_error <= 1'b1;
            end
        end
    end

    //-------------------------------------------------------------------------
    // Outputs: decoded from registered state and registers only, so there is
    // no combinational path from dma_ready or abort to the bus.
    //-------------------------------------------------------------------------
    always_comb begin
        dma_addr = 16'h0000;
        case (r_state)
            S_READ:  dma_addr = r_src;
            S_WRITE: dma_addr = r_dst;
            default: dma_addr = 16'h0000;
        endcase
    end

    assign dma_en   = (r_state == S_READ) || (r_state == S_WRITE);
    assign dma_we   = (r_state == S_WRITE);
    assign dma_dout = r_data;
    assign busy     = (r_state == S_READ) || (r_state == S_WRITE);
    assign done     = (r_state == S_DONE);
    assign error    = r_error;

endmodule

// File: tb/tb_dma_xfer_engine.sv
`timescale 1ns/1ps

module tb_dma_xfer_engine;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] cfg_src;
    logic [15:0] cfg_dst;
    logic [7:0]  cfg_len;
    logic        abort;
    logic [15:0] dma_addr;
    logic        dma_en;
    logic        dma_we;
    logic [15:0] dma_dout;
    logic [15:0] dma_din;
    logic        dma_ready;
    logic        busy;
    logic        done;
    logic        error;

    // Memory read data: address XOR A5A5 unless a test overrides it.
    logic        din_ovr_en;
    logic [15:0] din_ovr;

    dma_xfer_engine #(
        .LEN_W     (8),
        .ADDR_STEP (16'h0002)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .cfg_src   (cfg_src),
        .cfg_dst   (cfg_dst),
        .cfg_len   (cfg_len),
        .abort     (abort),
        .dma_addr  (dma_addr),
        .dma_en    (dma_en),
        .dma_we    (dma_we),
        .dma_dout  (dma_dout),
        .dma_din   (dma_din),
        .dma_ready (dma_ready),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        dma_din = din_ovr_en ? din_ovr : (dma_addr ^ 16'hA5A5);
    end

    // Scoreboard entry: kind 0 = read, 1 = write, 2 = done pulse.
    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic exp_push(input int k, input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    // Monitor: every completed bus access and every done pulse is matched
    // against the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (dma_en && dma_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_miss++;
                    $display("FAIL bus: unexpected %s @%h data %h",
                             dma_we ? "W" : "R", dma_addr, dma_dout);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if ((e.kind != int'(dma_we)) || (e.addr !== dma_addr) ||
                        (dma_we && (e.data !== dma_dout))) begin
                        n_miss++;
                        $display("FAIL bus: got %s @%h data %h required kind %0d @%h data %h",
                                 dma_we ? "W" : "R", dma_addr, dma_dout, e.kind, e.addr, e.data);
                    end else begin
                        $display("ok   bus: %s @%h data %h", dma_we ? "W" : "R",
                                 dma_addr, dma_we ? dma_dout : dma_din);
                    end
                end
            end
            if (done) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_miss++;
                    $display("FAIL done: unexpected done pulse, required none");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.kind != 2) begin
                        n_miss++;
                        $display("FAIL done: got done pulse, required kind %0d @%h", e.kind, e.addr);
                    end else begin
                        $display("ok   done: pulse");
                    end
                end
            end
        end
    end

    // Start is high for the cycle before the sampling edge; the task returns
    // just after that edge, inside the first cycle of the transfer.
    task automatic do_start(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l);
        @(posedge clk); #1;
        cfg_src = s;
        cfg_dst = d;
        cfg_len = l;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        cfg_src = 16'hDEAD;
        cfg_dst = 16'hBEEF;
        cfg_len = 8'hFF;
    endtask

    // Counts cycles after the start edge until done; bounded.
    task automatic wait_done(input string nm, input int req_n, input bit no_en);
        int n;
        bit en_seen;
        n = 0;
        en_seen = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (dma_en) en_seen = 1'b1;
            if (done) begin
                n = i;
                break;
            end
        end
        chk({nm, " done latency"}, 48'(n), 48'(req_n));
        chk({nm, " error at done"}, 48'(error), 48'd0);
        if (no_en) chk({nm, " no bus access"}, 48'(en_seen), 48'd0);
    endtask

    initial begin
        logic [6:0] pat;
        reset_n    = 1'b0;
        start      = 1'b0;
        cfg_src    = 16'h0;
        cfg_dst    = 16'h0;
        cfg_len    = 8'h0;
        abort      = 1'b0;
        dma_ready  = 1'b1;
        din_ovr_en = 1'b0;
        din_ovr    = 16'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", {dma_en, dma_we, busy, done, error, dma_addr, dma_dout},
            48'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic copy, ready always high
        exp_push(0, 16'h0200, 16'h0);
        exp_push(1, 16'h0300, 16'hA7A5);
        exp_push(0, 16'h0202, 16'h0);
        exp_push(1, 16'h0302, 16'hA7A7);
        exp_push(0, 16'h0204, 16'h0);
        exp_push(1, 16'h0304, 16'hA7A1);
        exp_push(2, 16'h0, 16'h0);
        do_start(16'h0200, 16'h0300, 8'd3);
        wait_done("basic", 7, 1'b0);

        // Wait states: 2 in READ, 3 in WRITE
        dma_ready  = 1'b0;
        din_ovr_en = 1'b1;
        din_ovr    = 16'hA5C3;
        exp_push(0, 16'h0400, 16'h0);
        exp_push(1, 16'h0500, 16'hA5C3);
        exp_push(2, 16'h0, 16'h0);
        do_start(16'h0400, 16'h0500, 8'd1);
        pat = 7'b1000100;
        for (int i = 0; i < 7; i++) begin
            dma_ready = pat[i];
            @(negedge clk);
            if (i < 3)
                chk("wait read hold", {30'd0, dma_en, dma_we, dma_addr}, {30'd0, 1'b1, 1'b0, 16'h0400});
            else
                chk("wait write hold", {14'd0, dma_en, dma_we, dma_addr, dma_dout},
                    {14'd0, 1'b1, 1'b1, 16'h0500, 16'hA5C3});
            @(posedge clk); #1;
        end
        dma_ready  = 1'b1;
        din_ovr_en = 1'b0;
        @(negedge clk);
        chk("wait done at cycle 8", 48'(done), 48'd1);

        // Zero length
        exp_push(2, 16'h0, 16'h0);
        do_start(16'h0600, 16'h0700, 8'd0);
        wait_done("zero len", 1, 1'b1);

        // Odd addresses are word aligned
        exp_push(0, 16'h0200, 16'h0);
        exp_push(1, 16'h0800, 16'hA7A5);
        exp_push(2, 16'h0, 16'h0);
        do_start(16'h0201, 16'h0801, 8'd1);
        wait_done("align", 3, 1'b0);

        // Address wrap
        exp_push(0, 16'hFFFE, 16'h0);
        exp_push(1, 16'h1000, 16'h5A5B);
        exp_push(0, 16'h0000, 16'h0);
        exp_push(1, 16'h1002, 16'hA5A5);
        exp_push(2, 16'h0, 16'h0);
        do_start(16'hFFFE, 16'h1000, 8'd2);
        wait_done("wrap", 5, 1'b0);

        // Abort in the second WRITE, coincident with ready
        exp_push(0, 16'h0200, 16'h0);
        exp_push(1, 16'h0300, 16'hA7A5);
        exp_push(0, 16'h0202, 16'h0);
        exp_push(1, 16'h0302, 16'hA7A7);
        do_start(16'h0200, 16'h0300, 8'd4);
        repeat (3) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort bus dropped", {45'd0, dma_en, busy, done}, 48'd0);
        chk("abort error set", 48'(error), 48'd1);
        repeat (4) @(negedge clk);
        chk("abort error sticky", 48'(error), 48'd1);

        // Restart after abort clears error
        exp_push(0, 16'h0600, 16'h0);
        exp_push(1, 16'h0700, 16'hA3A5);
        exp_push(2, 16'h0, 16'h0);
        do_start(16'h0600, 16'h0700, 8'd1);
        chk("restart error cleared", 48'(error), 48'd0);
        wait_done("restart", 3, 1'b0);

        // Asynchronous reset in the middle of a READ
        dma_ready = 1'b0;
        do_start(16'h0200, 16'h0300, 8'd1);
        @(negedge clk);
        chk("pre-reset read", {31'd0, dma_en, dma_addr}, {31'd0, 1'b1, 16'h0200});
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset outputs", {dma_en, dma_we, busy, done, error, dma_addr, dma_dout},
            48'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        dma_ready = 1'b1;

        exp_push(0, 16'h0A00, 16'h0);
        exp_push(1, 16'h0B00, 16'hAFA5);
        exp_push(2, 16'h0, 16'h0);
        do_start(16'h0A00, 16'h0B00, 8'd1);
        wait_done("post reset", 3, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard drained", 48'(sb.size()), 48'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
